// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit CPU core and its host-side program sequencer.
// Holds opcode constants, ALU op codes, the NOP encoding and program-word field offsets.
package cpu_isa_pkg;

    localparam logic [3:0] OP_MVR = 4'h0;
    localparam logic [3:0] OP_LDB = 4'h1;
    localparam logic [3:0] OP_STB = 4'h2;
    localparam logic [3:0] OP_RDS = 4'h3;
    localparam logic [3:0] OP_NOP = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_ADD = 4'hB;
    localparam logic [3:0] OP_SUB = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;

    typedef enum logic [3:0] {
        ALU_AND = 4'h5,
        ALU_OR  = 4'h6,
        ALU_XOR = 4'h7,
        ALU_NOT = 4'h8,
        ALU_SHL = 4'h9,
        ALU_SHR = 4'hA,
        ALU_ADD = 4'hB,
        ALU_SUB = 4'hC,
        ALU_MUL = 4'hD
    } alu_op_e;

    localparam logic [7:0] NOP_WORD = {OP_NOP, 4'h0};

    // load_data layout: {opcode, r1, r2/data-hi, r3/data-lo}
    localparam int OPC_MSB = 15;
    localparam int R1_MSB  = 11;
    localparam int R2_MSB  = 7;
    localparam int R3_MSB  = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    // Only STB and RDS drive a fresh value onto the core's data_out.
    function automatic logic is_capture(input logic [3:0] opcode);
        return (opcode == OP_STB) || (opcode == OP_RDS);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible on pop_data whenever valid is high.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && valid;
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_prog_sequencer.sv
// Host-side driver for the 8-bit CPU core: buffers a program, issues one word per cycle,
// and captures data_out after every STB/RDS into a result FIFO.
module cpu_prog_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int PROG_DEPTH     = 16,
    parameter int LOG_PROG_DEPTH = 4,
    parameter int RES_DEPTH      = 4,
    parameter int BIT_WIDTH_REG  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_clr,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [2*BIT_WIDTH_REG-1:0] load_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [BIT_WIDTH_REG-1:0]   cpu_inst,
    output logic [BIT_WIDTH_REG-1:0]   cpu_operand,
    input  logic [BIT_WIDTH_REG-1:0]   cpu_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [BIT_WIDTH_REG-1:0]   res_data,
    output seq_state_e                 fsm_state
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int PW    = 2 * BIT_WIDTH_REG;

    // Handshakes (load and result): a word moves on a rising edge where valid and ready
    // are both high; valid never depends on ready.
    logic [PW-1:0]             mem [PROG_DEPTH];
    logic [LOG_PROG_DEPTH:0]   prog_count;
    logic [LOG_PROG_DEPTH-1:0] pc;
    seq_state_e                state;
    seq_state_e                state_next;
    logic [PW-1:0]             word;
    logic                      word_is_capture;
    logic                      last_word;
    logic                      stall;
    logic                      issue;
    logic                      load_fire;
    logic                      tag0;
    logic                      tag1;
    logic [CNT_W-1:0]          fifo_count;
    logic [OCC_W-1:0]          occupancy;

    assign fsm_state  = state;
    assign busy       = (state == SEQ_RUN) || (state == SEQ_DRAIN);
    assign done       = (state == SEQ_DONE);
    assign load_ready = (state == SEQ_IDLE) && (prog_count < (LOG_PROG_DEPTH+1)'(PROG_DEPTH));
    assign load_fire  = load_valid && load_ready && !prog_clr;

    assign word            = mem[pc];
    assign word_is_capture = is_capture(word[OPC_MSB -: 4]);
    assign last_word       = ({1'b0, pc} == (prog_count - (LOG_PROG_DEPTH+1)'(1)));

    // Results already queued plus those still in the two-stage capture pipe.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(tag0) + OCC_W'(tag1);
    assign stall     = word_is_capture && (occupancy >= OCC_W'(RES_DEPTH));

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) begin
                    state_next = (prog_count == '0) ? SEQ_DONE : SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (last_word) state_next = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (!tag0 && !tag1) state_next = SEQ_DONE;
            end
            SEQ_DONE: begin
                state_next = SEQ_IDLE;
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[prog_count[LOG_PROG_DEPTH-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prog_count <= '0;
            pc         <= '0;
        end else begin
            if (state == SEQ_IDLE && prog_clr) begin
                prog_count <= '0;
            end else if (load_fire) begin
                prog_count <= prog_count + 1'b1;
            end
            if (state == SEQ_IDLE && start) begin
                pc <= '0;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
        end
    end

    // tag0 marks the cycle a capture word sits on the core inputs; tag1 the cycle its
    // result is valid on cpu_data, which is pushed at the end of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_inst    <= NOP_WORD;
            cpu_operand <= '0;
            tag0        <= 1'b0;
            tag1        <= 1'b0;
        end else begin
            cpu_inst    <= issue ? word[PW-1 -: BIT_WIDTH_REG] : NOP_WORD;
            cpu_operand <= issue ? word[BIT_WIDTH_REG-1:0] : '0;
            tag0        <= issue && word_is_capture;
            tag1        <= tag0;
        end
    end

    sync_fifo #(
        .WIDTH (BIT_WIDTH_REG),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag1),
        .push_data (cpu_data),
        .pop       (res_ready),
        .pop_data  (res_data),
        .valid     (res_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// Directed bench for cpu_prog_sequencer driving a minimal stand-in of the 8-bit core
// (LDB/STB/RDS/ADD), with hand-computed expected instruction streams and results.
module tb_cpu_prog_sequencer;
    import cpu_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_clr;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  cpu_inst;
    logic [7:0]  cpu_operand;
    logic [7:0]  cpu_data;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    seq_state_e  fsm_state;

    int compared   = 0;
    int mismatched = 0;
    int issued_cnt = 0;
    int done_cnt   = 0;
    logic [7:0] exp_q[$];

    // Stand-in core state
    logic [7:0] rf [16];
    logic       carry;

    cpu_prog_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_clr    (prog_clr),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cpu_inst    (cpu_inst),
        .cpu_operand (cpu_operand),
        .cpu_data    (cpu_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- stand-in core ----------------
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
            carry    <= 1'b0;
            cpu_data <= 8'h00;
        end else begin
            case (cpu_inst[7:4])
                OP_LDB: rf[cpu_inst[3:0]] <= cpu_operand;
                OP_STB: cpu_data <= rf[cpu_inst[3:0]];
                OP_RDS: cpu_data <= {7'b0, carry};
                OP_ADD: {carry, rf[cpu_inst[3:0]]} <=
                        {1'b0, rf[cpu_operand[7:4]]} + {1'b0, rf[cpu_operand[3:0]]};
                default: ;
            endcase
        end
    end

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        if (!rst && cpu_inst !== NOP_WORD) issued_cnt <= issued_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] w, input string tag);
        check(tag, {15'b0, load_ready}, 16'h1);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic clear_prog();
        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int snap, input string tag);
        for (int i = 0; i < 80; i++) begin
            if (done_cnt > snap) break;
            tick();
        end
        check(tag, {15'b0, done_cnt > snap}, 16'h1);
    endtask

    task automatic pop_expect(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        for (int i = 0; i < 40; i++) begin
            if (res_valid === 1'b1) break;
            tick();
        end
        check({tag, "_valid"}, {15'b0, res_valid}, 16'h1);
        check({tag, "_data"}, {8'h0, res_data}, {8'h0, e});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int snap_i;
        int snap_d;
        rst        = 1'b1;
        prog_clr   = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        start      = 1'b0;
        res_ready  = 1'b0;
        tick();
        tick();
        check("rst_cpu_inst", {8'h0, cpu_inst}, 16'h0040);
        check("rst_cpu_operand", {8'h0, cpu_operand}, 16'h0000);
        check("rst_load_ready", {15'b0, load_ready}, 16'h1);
        check("rst_busy", {15'b0, busy}, 16'h0);
        check("rst_done", {15'b0, done}, 16'h0);
        check("rst_res_valid", {15'b0, res_valid}, 16'h0);
        rst = 1'b0;
        tick();

        // 1: LDB r1,5A ; STB r1
        load_word(16'h115A, "t1_load0");
        load_word(16'h2100, "t1_load1");
        snap_d = done_cnt;
        pulse_start();
        check("t1_busy", {15'b0, busy}, 16'h1);
        check("t1_inst_pre", {8'h0, cpu_inst}, 16'h0040);
        tick();
        check("t1_inst0", {8'h0, cpu_inst}, 16'h0011);
        check("t1_oper0", {8'h0, cpu_operand}, 16'h005A);
        tick();
        check("t1_inst1", {8'h0, cpu_inst}, 16'h0021);
        check("t1_oper1", {8'h0, cpu_operand}, 16'h0000);
        tick();
        check("t1_inst2", {8'h0, cpu_inst}, 16'h0040);
        check("t1_drain", {14'b0, fsm_state}, {14'b0, SEQ_DRAIN});
        wait_done(snap_d, "t1_done");
        check("t1_busy_after", {15'b0, busy}, 16'h0);
        check("t1_idle_after", {14'b0, fsm_state}, {14'b0, SEQ_IDLE});
        exp_q.push_back(8'h5A);
        pop_expect("t1_res");
        check("t1_fifo_empty", {15'b0, res_valid}, 16'h0);

        // 2: F0+20 sets carry; RDS then STB r2
        clear_prog();
        load_word(16'h10F0, "t2_load0");
        load_word(16'h1120, "t2_load1");
        load_word(16'hB201, "t2_load2");
        load_word(16'h3000, "t2_load3");
        load_word(16'h2200, "t2_load4");
        snap_d = done_cnt;
        snap_i = issued_cnt;
        pulse_start();
        wait_done(snap_d, "t2_done");
        check("t2_issued", 16'(issued_cnt - snap_i), 16'd5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h10);
        pop_expect("t2_res0");
        pop_expect("t2_res1");
        check("t2_fifo_empty", {15'b0, res_valid}, 16'h0);

        // 3: six captures with the consumer stalled
        clear_prog();
        load_word(16'h1177, "t3_load_ldb");
        for (int i = 0; i < 6; i++) load_word(16'h2100, "t3_load_stb");
        snap_d = done_cnt;
        snap_i = issued_cnt;
        pulse_start();
        for (int i = 0; i < 20; i++) tick();
        check("t3_issued_stalled", 16'(issued_cnt - snap_i), 16'd5);
        check("t3_stall_nop", {8'h0, cpu_inst}, 16'h0040);
        check("t3_stall_busy", {15'b0, busy}, 16'h1);
        check("t3_stall_state", {14'b0, fsm_state}, {14'b0, SEQ_RUN});
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h77);
        for (int i = 0; i < 6; i++) pop_expect("t3_res");
        wait_done(snap_d, "t3_done");
        check("t3_issued_total", 16'(issued_cnt - snap_i), 16'd7);
        check("t3_fifo_empty", {15'b0, res_valid}, 16'h0);

        // 4: fill the buffer to capacity, then clear
        clear_prog();
        for (int i = 0; i < 16; i++) load_word(16'h1100 | 16'(i), "t4_load");
        check("t4_full_ready", {15'b0, load_ready}, 16'h0);
        load_valid = 1'b1;
        load_data  = 16'h2100;
        tick();
        load_valid = 1'b0;
        snap_d = done_cnt;
        snap_i = issued_cnt;
        pulse_start();
        wait_done(snap_d, "t4_done16");
        check("t4_issued16", 16'(issued_cnt - snap_i), 16'd16);
        check("t4_no_result", {15'b0, res_valid}, 16'h0);
        clear_prog();
        check("t4_clr_ready", {15'b0, load_ready}, 16'h1);
        snap_i = issued_cnt;
        pulse_start();
        check("t4_empty_done", {15'b0, done}, 16'h1);
        check("t4_empty_busy", {15'b0, busy}, 16'h0);
        tick();
        check("t4_done_pulse", {15'b0, done}, 16'h0);
        check("t4_empty_issued", 16'(issued_cnt - snap_i), 16'd0);

        // clear and load in the same cycle: clear wins
        load_word(16'h1155, "t4_pre_load");
        prog_clr   = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h2100;
        tick();
        prog_clr   = 1'b0;
        load_valid = 1'b0;
        pulse_start();
        check("t4_clr_wins_done", {15'b0, done}, 16'h1);
        tick();

        // 5: reset with two captures in flight
        load_word(16'h1133, "t5_load0");
        for (int i = 0; i < 3; i++) load_word(16'h2100, "t5_load_stb");
        pulse_start();
        tick();
        tick();
        tick();
        check("t5_inflight_inst", {8'h0, cpu_inst}, 16'h0021);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_inst", {8'h0, cpu_inst}, 16'h0040);
        check("t5_rst_res_valid", {15'b0, res_valid}, 16'h0);
        check("t5_rst_busy", {15'b0, busy}, 16'h0);
        check("t5_rst_ready", {15'b0, load_ready}, 16'h1);
        tick();
        tick();
        check("t5_discarded", {15'b0, res_valid}, 16'h0);
        pulse_start();
        check("t5_restart_done", {15'b0, done}, 16'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
